// File: rtl/lsu_dmem_ctrl_if.sv
// Execute-stage request/response handshake plus the RAM data port of the load/store back end.
// master = execute stage and RAM side, slave = lsu_dmem_ctrl.
interface lsu_dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_misalign;
  logic        resp_fault;

  logic        dmem_en;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_rdata;
  logic [63:0] dmem_wdata;
  logic [63:0] dmem_wmask;
  logic        dmem_wen;

  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, dmem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_fault,
    input  dmem_en, dmem_addr, dmem_wdata, dmem_wmask, dmem_wen
  );

  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, dmem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign, resp_fault,
    output dmem_en, dmem_addr, dmem_wdata, dmem_wmask, dmem_wen
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Load/store back end: one request per transaction, 64-bit aligned RAM access with byte-lane
// write masking, load alignment and extension, and misalign/range rejection before memory.
module lsu_dmem_ctrl #(
  parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0000_0000_0800_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_dmem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic        accept;
  logic        req_ready;
  logic        resp_valid;
  logic        dmem_en;
  logic        dmem_wen;
  logic        req_misalign;
  logic        req_fault;

  logic [63:0] addr_p0;
  logic [1:0]  size_p0;
  logic        wen_p0;
  logic        unsigned_p0;
  logic [63:0] wdata_p0;
  logic        misalign_p0;
  logic        fault_p0;

  logic [63:0] rdata_p1;
  logic [63:0] load_raw;

  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [3:0] span;
    logic [2:0] low_mask;
    span     = 4'd1 << size;
    low_mask = 3'(span - 4'd1);
    return (off & low_mask) != 3'd0;
  endfunction

  // Offset from the base wraps for addresses below MEM_BASE, so one unsigned compare covers both ends.
  function automatic logic is_out_of_range(input logic [63:0] addr);
    logic [63:0] rel;
    rel = addr - MEM_BASE;
    return !(rel < MEM_SIZE);
  endfunction

  function automatic logic [7:0] lane_mask(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  function automatic logic [63:0] expand_mask(input logic [7:0] lanes);
    logic [63:0] m;
    m = '0;
    for (int b = 0; b < 8; b++) begin
      m[8*b +: 8] = {8{lanes[b]}};
    end
    return m;
  endfunction

  function automatic logic [63:0] extend_load(input logic [63:0] raw, input logic [1:0] size,
                                              input logic zext);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] r;
    b = raw[7:0];
    h = raw[15:0];
    w = raw[31:0];
    case (size)
      2'd0: begin
        if (zext) r = {56'd0, raw[7:0]};
        else      r = 64'(b);
      end
      2'd1: begin
        if (zext) r = {48'd0, raw[15:0]};
        else      r = 64'(h);
      end
      2'd2: begin
        if (zext) r = {32'd0, raw[31:0]};
        else      r = 64'(w);
      end
      default: r = raw;
    endcase
    return $unsigned(r);
  endfunction

  assign req_misalign = is_misaligned(bus.req_addr[2:0], bus.req_size);
  assign req_fault    = !req_misalign && is_out_of_range(bus.req_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dmem_en    = 1'b0;
    dmem_wen   = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = (req_misalign || req_fault) ? RESP : ACCESS;
        end
      end
      ACCESS: begin
        dmem_en   = 1'b1;
        dmem_wen  = wen_p0;
        state_nxt = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (bus.resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // p0: request captured at the IDLE handshake; only consumed while the FSM says it is valid.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0     <= bus.req_addr;
      size_p0     <= bus.req_size;
      wen_p0      <= bus.req_wen;
      unsigned_p0 <= bus.req_unsigned;
      wdata_p0    <= bus.req_wdata;
      misalign_p0 <= req_misalign;
      fault_p0    <= req_fault;
    end
  end

  assign load_raw = bus.dmem_rdata >> {addr_p0[2:0], 3'b000};

  // p1: response data, cleared on every new request so stores and rejected accesses return 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p1 <= '0;
    end else if (accept) begin
      rdata_p1 <= '0;
    end else if (state == ACCESS && !wen_p0) begin
      rdata_p1 <= extend_load(load_raw, size_p0, unsigned_p0);
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.resp_valid    = resp_valid;
  assign bus.resp_rdata    = rdata_p1;
  assign bus.resp_misalign = resp_valid && misalign_p0;
  assign bus.resp_fault    = resp_valid && fault_p0;

  assign bus.dmem_en    = dmem_en;
  assign bus.dmem_wen   = dmem_wen;
  assign bus.dmem_addr  = dmem_en ? {addr_p0[63:3], 3'b000} : '0;
  assign bus.dmem_wdata = dmem_en ? (wdata_p0 << {addr_p0[2:0], 3'b000}) : '0;
  assign bus.dmem_wmask = dmem_en ? expand_mask(lane_mask(addr_p0[2:0], size_p0)) : '0;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl with a 16-dword RAM model behind the dmem port.
module tb_lsu_dmem_ctrl;
  logic clk;
  logic rst_n;

  lsu_dmem_ctrl_if bus();

  lsu_dmem_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;

  logic [63:0] mem [16];
  logic        pl_en;
  logic [3:0]  pl_idx;
  logic [63:0] pl_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.dmem_rdata = mem[bus.dmem_addr[6:3]];

  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (bus.dmem_en && bus.dmem_wen) begin
      mem[bus.dmem_addr[6:3]] <= (mem[bus.dmem_addr[6:3]] & ~bus.dmem_wmask) |
                                 (bus.dmem_wdata & bus.dmem_wmask);
    end
    if (bus.dmem_en) en_cnt <= en_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] idx, input logic [63:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    tick();
    pl_en   = 1'b0;
  endtask

  // Returns one cycle after the accepting edge.
  task automatic send(input logic wen, input logic [1:0] size, input logic uns,
                      input logic [63:0] addr, input logic [63:0] wdata);
    int n;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      tick();
      n++;
    end
    chk("req_ready_wait", 64'(bus.req_ready), 64'd1);
    bus.req_valid    = 1'b1;
    bus.req_wen      = wen;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    tick();
    bus.req_valid    = 1'b0;
  endtask

  task automatic consume();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("resp_dropped", 64'(bus.resp_valid), 64'd0);
  endtask

  task automatic load(input string tag, input logic [1:0] size, input logic uns,
                      input logic [63:0] addr, input logic [63:0] exp);
    send(1'b0, size, uns, addr, 64'd0);
    chk({tag, "_en"}, 64'(bus.dmem_en), 64'd1);
    chk({tag, "_wen"}, 64'(bus.dmem_wen), 64'd0);
    tick();
    chk({tag, "_valid"}, 64'(bus.resp_valid), 64'd1);
    chk({tag, "_flags"}, {62'd0, bus.resp_misalign, bus.resp_fault}, 64'd0);
    chk({tag, "_rdata"}, bus.resp_rdata, exp);
    consume();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [63:0] held;
    rst_n            = 1'b1;
    pl_en            = 1'b0;
    pl_idx           = '0;
    pl_data          = '0;
    bus.req_valid    = 1'b0;
    bus.req_wen      = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;
    #1 rst_n = 1'b0;

    for (int i = 0; i < 16; i++) preload(4'(i), 64'd0);
    preload(4'd1,  64'h5555_5555_5555_5555);
    preload(4'd2,  64'h1122_3344_8899_AABB);
    preload(4'd15, 64'h0123_4567_89AB_CDEF);

    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_dmem_en", 64'(bus.dmem_en), 64'd0);
    chk("rst_wmask", bus.dmem_wmask, 64'd0);
    chk("rst_rdata", bus.resp_rdata, 64'd0);
    #2 rst_n = 1'b1;
    tick();

    // T1 store byte
    send(1'b1, 2'd0, 1'b0, 64'h8000_0005, 64'h0000_0000_0000_00AB);
    chk("t1_en", 64'(bus.dmem_en), 64'd1);
    chk("t1_wen", 64'(bus.dmem_wen), 64'd1);
    chk("t1_addr", bus.dmem_addr, 64'h0000_0000_8000_0000);
    chk("t1_wmask", bus.dmem_wmask, 64'h0000_FF00_0000_0000);
    chk("t1_wdata", bus.dmem_wdata, 64'h0000_AB00_0000_0000);
    chk("t1_req_ready", 64'(bus.req_ready), 64'd0);
    tick();
    chk("t1_valid", 64'(bus.resp_valid), 64'd1);
    chk("t1_rdata", bus.resp_rdata, 64'd0);
    chk("t1_en_off", 64'(bus.dmem_en), 64'd0);
    chk("t1_mem", mem[0], 64'h0000_AB00_0000_0000);
    consume();
    chk("t1_idle", 64'(bus.req_ready), 64'd1);

    // T2 byte loads
    load("t2_lb",  2'd0, 1'b0, 64'h8000_0005, 64'hFFFF_FFFF_FFFF_FFAB);
    load("t2_lbu", 2'd0, 1'b1, 64'h8000_0005, 64'h0000_0000_0000_00AB);

    // T3 wider loads and the top of the window
    load("t3_lw_hi", 2'd2, 1'b0, 64'h8000_0014, 64'h0000_0000_1122_3344);
    load("t3_lh",    2'd1, 1'b0, 64'h8000_0012, 64'hFFFF_FFFF_FFFF_8899);
    load("t3_lw_lo", 2'd2, 1'b0, 64'h8000_0010, 64'hFFFF_FFFF_8899_AABB);
    load("t3_lwu",   2'd2, 1'b1, 64'h8000_0010, 64'h0000_0000_8899_AABB);
    load("t3_ld",    2'd3, 1'b1, 64'h8000_0010, 64'h1122_3344_8899_AABB);
    load("t3_top",   2'd3, 1'b0, 64'h87FF_FFF8, 64'h0123_4567_89AB_CDEF);

    // T4 misaligned and out-of-range requests never reach memory
    c0 = en_cnt;
    send(1'b0, 2'd1, 1'b0, 64'h8000_0003, 64'd0);
    chk("t4_mis_valid", 64'(bus.resp_valid), 64'd1);
    chk("t4_mis_flags", {62'd0, bus.resp_misalign, bus.resp_fault}, 64'd2);
    chk("t4_mis_rdata", bus.resp_rdata, 64'd0);
    consume();
    send(1'b1, 2'd3, 1'b0, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t4_low_valid", 64'(bus.resp_valid), 64'd1);
    chk("t4_low_flags", {62'd0, bus.resp_misalign, bus.resp_fault}, 64'd1);
    consume();
    send(1'b0, 2'd0, 1'b0, 64'h8800_0000, 64'd0);
    chk("t4_end_flags", {62'd0, bus.resp_misalign, bus.resp_fault}, 64'd1);
    consume();
    send(1'b0, 2'd1, 1'b0, 64'h7FFF_FFF9, 64'd0);
    chk("t4_both_flags", {62'd0, bus.resp_misalign, bus.resp_fault}, 64'd2);
    consume();
    chk("t4_no_access", 64'(en_cnt - c0), 64'd0);
    chk("t4_mem0", mem[0], 64'h0000_AB00_0000_0000);

    // T5 backpressure with a competing request held on the bus
    send(1'b0, 2'd2, 1'b0, 64'h8000_0014, 64'd0);
    tick();
    held = bus.resp_rdata;
    chk("t5_first", held, 64'h0000_0000_1122_3344);
    bus.req_valid    = 1'b1;
    bus.req_wen      = 1'b0;
    bus.req_size     = 2'd3;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 64'h8000_0010;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_hold_valid", 64'(bus.resp_valid), 64'd1);
      chk("t5_hold_rdata", bus.resp_rdata, held);
      chk("t5_hold_ready", 64'(bus.req_ready), 64'd0);
      chk("t5_hold_en", 64'(bus.dmem_en), 64'd0);
    end
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk("t5_consumed", 64'(bus.resp_valid), 64'd0);
    chk("t5_no_accept", 64'(bus.dmem_en), 64'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("t5_next_en", 64'(bus.dmem_en), 64'd1);
    chk("t5_next_addr", bus.dmem_addr, 64'h0000_0000_8000_0010);
    tick();
    chk("t5_next_rdata", bus.resp_rdata, 64'h1122_3344_8899_AABB);
    consume();

    // Half store in the top lanes; the upper store bits fall outside the mask
    send(1'b1, 2'd1, 1'b0, 64'h8000_0016, 64'h0000_0000_1234_ABCD);
    chk("sh_wmask", bus.dmem_wmask, 64'hFFFF_0000_0000_0000);
    chk("sh_wdata", bus.dmem_wdata, 64'hABCD_0000_0000_0000);
    tick();
    consume();
    load("sh_readback", 2'd3, 1'b0, 64'h8000_0010, 64'hABCD_3344_8899_AABB);

    // T6 reset during ACCESS
    send(1'b1, 2'd3, 1'b0, 64'h8000_0008, 64'hDEAD_BEEF_CAFE_F00D);
    chk("t6_en", 64'(bus.dmem_en), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_en_drop", 64'(bus.dmem_en), 64'd0);
    chk("t6_valid", 64'(bus.resp_valid), 64'd0);
    chk("t6_ready", 64'(bus.req_ready), 64'd1);
    tick();
    chk("t6_mem", mem[1], 64'h5555_5555_5555_5555);
    rst_n = 1'b1;
    tick();
    chk("t6_ready_rel", 64'(bus.req_ready), 64'd1);
    chk("t6_valid_rel", 64'(bus.resp_valid), 64'd0);
    load("t6_readback", 2'd3, 1'b0, 64'h8000_0008, 64'h5555_5555_5555_5555);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
